load_unit: RTL and testbench
============================

// Module: load_unit
// PURPOSE
//  Multi-cycle data-memory reader for the load path: accepts a load command,
//  issues a word-aligned req/ack read to data memory, extracts the byte, halfword
//  or word and sign/zero-extends it for register writeback.
//  It is the read-side counterpart to the write-side extension in the register
//  path, and sits between the control FSM and data memory in the multi-cycle core.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in REQ without mem_ack before aborting with err (>=1)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   load command strobe; accepted only in IDLE
//  addr       in   32  byte address of load
//  funct3     in   3   000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
//  mem_req    out  1   memory read request, held high until ack
//  mem_addr   out  32  {addr_q[31:2],2'b00}
//  mem_ack    in   1   memory accepted; mem_rdata valid this same cycle
//  mem_rdata  in   32  little-endian memory word
//  busy       out  1   high in any state other than IDLE
//  done       out  1   one-cycle completion pulse
//  err        out  1   valid with done: illegal funct3, timeout, or misaligned (macro)
//  rdata      out  32  extended load result; valid with done, held until next start
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; mem_req, busy, done, err=0; rdata, mem_addr=0;
//   timeout counter=0. Reset mid-operation aborts immediately, with no done pulse.
//  States: IDLE -> REQ -> DONE -> IDLE.
//   IDLE: on start, latch addr_q and funct3_q and check legality. If legal, go to REQ.
//     If illegal, go straight to DONE with err=1 and rdata=0; no memory request is issued.
//   REQ: mem_req=1 and the counter increments each cycle.
//     On mem_ack, capture mem_rdata, extend it into rdata, go to DONE.
//     If the counter reaches TIMEOUT_CYCLES without ack: drop mem_req, err=1, rdata=0, go to DONE.
//   DONE: done=1 for exactly one cycle, then IDLE; err is cleared at the next accepted start.
//  Latency: start at cycle N -> mem_req high from N+1; ack at cycle N+k -> done at N+k+1.
//   Zero-wait memory gives a 2-cycle load.
//  Extraction (off = addr_q[1:0]):
//   byte = mem_rdata[8*off +: 8]
//   half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0]
//   LB/LH sign-extend from bit 7/15; LBU/LHU zero-fill; LW passes the word through.
//  start while busy is ignored, with no queuing.
//  A mem_ack outside REQ is ignored.
//  mem_addr is stable for the whole REQ state.
//  An ack in the same cycle the counter hits its limit counts as success.
// CONFIGURATION
//  LOAD_MISALIGN_TRAP_EN defined: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0,
//   goes IDLE->DONE with err=1 and rdata=0; no mem_req is issued.
//  Not defined: misaligned access is not checked. The halfword select uses addr[1] only,
//   LW ignores addr[1:0], and err flags only illegal funct3 and timeout.
// TESTING
//  1 LB at addr 0x103, mem_rdata 0x80FF1234, ack immediate -> rdata 0xFFFFFF80,
//    err=0, done at start+2.
//  2 LBU same access -> rdata 0x00000080.
//  3 LH at 0x102, mem_rdata 0x80017FFF -> 0xFFFF8001.
//    LHU at 0x100 -> 0x00007FFF.
//  4 LW at 0x200 with ack delayed 3 cycles -> mem_addr 0x200, done at start+4,
//    rdata = mem_rdata; a second start while busy is ignored.
//  5 No ack -> mem_req drops after 16 cycles, done with err=1 and rdata=0.
//    funct3=011 -> done at start+1 with err=1 and no mem_req.
//  6 rst low during REQ -> mem_req, busy, done all 0 immediately, no done pulse.
//    With LOAD_MISALIGN_TRAP_EN: LW at 0x201 -> err=1 and no mem_req.

Source files
------------

// File: rtl/load_unit.sv
// Multi-cycle load unit: word-aligned req/ack read, byte/half/word extraction.
// Optional misaligned-access trap: define LOAD_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module load_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [CW-1:0] cnt;
  logic          legal;
  logic [31:0]   sh;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ext;

  always_comb begin
    legal = 1'b0;
    unique case (funct3)
      3'b000, 3'b100: legal = 1'b1;
`ifdef LOAD_MISALIGN_TRAP_EN
      3'b001, 3'b101: legal = ~addr[0];
      3'b010:         legal = (addr[1:0] == 2'b00);
`else
      3'b001, 3'b101: legal = 1'b1;
      3'b010:         legal = 1'b1;
`endif
      default:        legal = 1'b0;
    endcase
  end

  // Byte lane picked by shifting the word down by 8*offset.
  always_comb begin
    sh     = mem_rdata >> {off_q, 3'b000};
    byte_v = sh[7:0];
    half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext    = 32'd0;
    unique case (f3_q)
      3'b000:  ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext = {{16{half_v[15]}}, half_v};
      3'b010:  ext = mem_rdata;
      3'b100:  ext = {24'd0, byte_v};
      3'b101:  ext = {16'd0, half_v};
      default: ext = 32'd0;
    endcase
  end

  assign mem_req = (state == REQ);
  assign done    = (state == DONE);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      off_q    <= 2'd0;
      f3_q     <= 3'd0;
      cnt      <= '0;
      mem_addr <= 32'd0;
      rdata    <= 32'd0;
      err      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            off_q    <= addr[1:0];
            f3_q     <= funct3;
            mem_addr <= {addr[31:2], 2'b00};
            cnt      <= '0;
            rdata    <= 32'd0;
            err      <= ~legal;
            state    <= legal ? REQ : DONE;
          end
        end
        REQ: begin
          // Ack wins over the timeout on the limit cycle.
          if (mem_ack) begin
            rdata <= ext;
            state <= DONE;
          end else if (cnt == LIM) begin
            err   <= 1'b1;
            rdata <= 32'd0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit.
// Covers extraction, latency, timeout, reset abort and LOAD_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_fail = 0;

  load_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .funct3(funct3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_at: cycle index after start at which ack is raised (0 = never).
  // poke: issue a second start (LB 0x303) while busy.
  task automatic run_load(
    input  logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
    input  int ack_at, input logic poke,
    output int lat, output int reqc, output logic [31:0] maddr
  );
    start = 1'b1; addr = a; funct3 = f; mem_rdata = d; mem_ack = 1'b0;
    lat = 0; reqc = 0; maddr = 32'hDEAD_BEEF;
    step();
    start = 1'b0;
    lat = 1;
    while (1) begin
      if (mem_req) begin
        if (reqc == 0) maddr = mem_addr;
        else if (mem_addr !== maddr) maddr = 32'hBAD0_BAD0;
        reqc++;
      end
      if (done || lat >= 64) break;
      mem_ack = (ack_at != 0 && lat >= ack_at);
      if (poke && lat == 2) begin
        start = 1'b1; addr = 32'h303; funct3 = 3'b000;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    mem_ack = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_cmp++;
    if ({mem_req, busy, done, err} !== 4'b0 || rdata !== 0 || mem_addr !== 0) begin
      n_fail++;
      $display("FAIL reset: req=%b busy=%b done=%b err=%b rdata=%h maddr=%h want all 0",
               mem_req, busy, done, err, rdata, mem_addr);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_byte();
    int lat, reqc;
    logic [31:0] ma;
    run_load(32'h103, 3'b000, 32'h80FF1234, 1, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (rdata !== 32'hFFFFFF80 || err !== 1'b0 || lat != 2) begin
      n_fail++;
      $display("FAIL lb: rdata=%h err=%b lat=%0d want ffffff80 0 2", rdata, err, lat);
    end
    n_cmp++;
    if (ma !== 32'h100 || reqc != 1) begin
      n_fail++;
      $display("FAIL lb_addr: maddr=%h reqc=%0d want 00000100 1", ma, reqc);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b busy=%b rdata=%h want 0 0 ffffff80",
               done, busy, rdata);
    end
    run_load(32'h103, 3'b100, 32'h80FF1234, 1, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (rdata !== 32'h00000080 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL lbu: rdata=%h err=%b want 00000080 0", rdata, err);
    end
    step();
    run_load(32'h101, 3'b000, 32'h80FF1234, 1, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (rdata !== 32'h00000012) begin
      n_fail++;
      $display("FAIL lb_off1: rdata=%h want 00000012", rdata);
    end
    step();
  endtask

  task automatic test_half();
    int lat, reqc;
    logic [31:0] ma;
    run_load(32'h102, 3'b001, 32'h80017FFF, 1, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (rdata !== 32'hFFFF8001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL lh: rdata=%h err=%b want ffff8001 0", rdata, err);
    end
    step();
    run_load(32'h100, 3'b101, 32'h80017FFF, 1, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (rdata !== 32'h00007FFF || err !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu: rdata=%h err=%b want 00007fff 0", rdata, err);
    end
    step();
  endtask

  task automatic test_word_delayed();
    int lat, reqc;
    logic [31:0] ma;
    run_load(32'h200, 3'b010, 32'hCAFEF00D, 3, 1'b1, lat, reqc, ma);
    n_cmp++;
    if (rdata !== 32'hCAFEF00D || err !== 1'b0 || lat != 4) begin
      n_fail++;
      $display("FAIL lw_delay: rdata=%h err=%b lat=%0d want cafef00d 0 4", rdata, err, lat);
    end
    n_cmp++;
    if (ma !== 32'h200 || reqc != 3) begin
      n_fail++;
      $display("FAIL lw_maddr: maddr=%h reqc=%0d want 00000200 3", ma, reqc);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_start_ignored: busy=%b req=%b want 0 0", busy, mem_req);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL idle_ack: busy=%b done=%b rdata=%h want 0 0 cafef00d",
               busy, done, rdata);
    end
  endtask

  task automatic test_timeout();
    int lat, reqc;
    logic [31:0] ma;
    run_load(32'h300, 3'b010, 32'h12345678, 0, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (err !== 1'b1 || rdata !== 0 || reqc != 16 || lat != 17 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: err=%b rdata=%h reqc=%0d lat=%0d want 1 0 16 17",
               err, rdata, reqc, lat);
    end
    step();
    run_load(32'h300, 3'b010, 32'h12345678, 16, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (err !== 1'b0 || rdata !== 32'h12345678 || lat != 17) begin
      n_fail++;
      $display("FAIL ack_at_limit: err=%b rdata=%h lat=%0d want 0 12345678 17",
               err, rdata, lat);
    end
    step();
    run_load(32'h100, 3'b011, 32'h12345678, 1, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (err !== 1'b1 || rdata !== 0 || lat != 1 || reqc != 0) begin
      n_fail++;
      $display("FAIL illegal_f3: err=%b rdata=%h lat=%0d reqc=%0d want 1 0 1 0",
               err, rdata, lat, reqc);
    end
    step();
    run_load(32'h100, 3'b100, 32'h000000AB, 1, 1'b0, lat, reqc, ma);
    n_cmp++;
    if (err !== 1'b0 || rdata !== 32'h000000AB) begin
      n_fail++;
      $display("FAIL err_clear: err=%b rdata=%h want 0 000000ab", err, rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    start = 1'b1; addr = 32'h400; funct3 = 3'b010;
    step();
    start = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_req: req=%b want 1", mem_req);
    end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: req=%b busy=%b done=%b want 0 0 0", mem_req, busy, done);
    end
    mem_ack = 1'b1;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) seen_done++;
      step();
    end
    mem_ack = 1'b0;
    n_cmp++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: active_cycles=%0d want 0", seen_done);
    end
  endtask

  task automatic test_misalign();
    int lat, reqc;
    logic [31:0] ma;
    run_load(32'h201, 3'b010, 32'h89ABCDEF, 1, 1'b0, lat, reqc, ma);
`ifdef LOAD_MISALIGN_TRAP_EN
    n_cmp++;
    if (err !== 1'b1 || rdata !== 0 || reqc != 0 || lat != 1) begin
      n_fail++;
      $display("FAIL misalign_lw: err=%b rdata=%h reqc=%0d lat=%0d want 1 0 0 1",
               err, rdata, reqc, lat);
    end
`else
    n_cmp++;
    if (err !== 1'b0 || rdata !== 32'h89ABCDEF || ma !== 32'h200 || lat != 2) begin
      n_fail++;
      $display("FAIL misalign_lw: err=%b rdata=%h maddr=%h lat=%0d want 0 89abcdef 200 2",
               err, rdata, ma, lat);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_word_delayed();
    test_timeout();
    test_reset_mid();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
